// File: rtl/flag_branch_pkg.sv
// Shared definitions for the flag branch unit: condition codes, FSM states, counter width.
package flag_branch_pkg;

   localparam int PEND_W_DEF = 3;

   localparam logic [3:0] COND_NEVER  = 4'd0;
   localparam logic [3:0] COND_ALWAYS = 4'd1;
   localparam logic [3:0] COND_EQ     = 4'd2;
   localparam logic [3:0] COND_NE     = 4'd3;
   localparam logic [3:0] COND_LT     = 4'd4;
   localparam logic [3:0] COND_GE     = 4'd5;
   localparam logic [3:0] COND_CS     = 4'd6;
   localparam logic [3:0] COND_CC     = 4'd7;
   localparam logic [3:0] COND_LE     = 4'd8;
   localparam logic [3:0] COND_GT     = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESOLVE = 2'd2
   } state_t;

   // NEVER, ALWAYS and the reserved codes resolve without looking at any flag.
   function automatic logic cond_uses_flags(input logic [3:0] cond);
      return (cond >= COND_EQ) && (cond <= COND_GT);
   endfunction

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational condition evaluator: maps a condition code and z/s/c flags to taken.
module flag_cond_eval
   import flag_branch_pkg::*;
(
   input  logic [3:0] cond,
   input  logic       z,
   input  logic       s,
   input  logic       c,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_ALWAYS: taken = 1'b1;
         COND_EQ:     taken = z;
         COND_NE:     taken = !z;
         COND_LT:     taken = s;
         COND_GE:     taken = !s;
         COND_CS:     taken = c;
         COND_CC:     taken = !c;
         COND_LE:     taken = z | s;
         COND_GT:     taken = !z & !s;
         default:     taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_branch_unit.sv
// Conditional-branch resolver that stalls until all older flag writers have committed.
// Build option FLAG_BYPASS_EN: resolve in the final commit cycle using the raw ALU flags.
module flag_branch_unit
   import flag_branch_pkg::*;
#(
   parameter int PEND_W = PEND_W_DEF,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [3:0]        br_cond,
   input  logic [ADDR_W-1:0] br_target,
   input  logic [ADDR_W-1:0] br_pc4,
   input  logic              fw_issue,
   input  logic              fw_commit,
   input  logic              dzf,
   input  logic              dsf,
   input  logic              dcf,
   input  logic              zf,
   input  logic              sf,
   input  logic              cf,
   output logic              res_valid,
   output logic              res_taken,
   output logic [ADDR_W-1:0] pc_next,
   output logic              pend_ovf
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   state_t              state, state_nxt;
   logic [PEND_W-1:0]   pend, pend_nxt;
   logic                ovf_set;
   logic [3:0]          lat_cond;
   logic [ADDR_W-1:0]   lat_target, lat_pc4;
   logic [3:0]          eval_cond;
   logic [ADDR_W-1:0]   eval_target, eval_pc4;
   logic                flags_ready, resolve_go, taken_eval;
   logic                flag_z, flag_s, flag_c;
   logic                load_req, load_res;

   always_comb begin
      pend_nxt = pend;
      ovf_set  = 1'b0;
      if (fw_issue && !fw_commit) begin
         if (pend == PEND_MAX) ovf_set  = 1'b1;
         else                  pend_nxt = pend + 1'b1;
      end else if (fw_commit && !fw_issue && pend != '0) begin
         pend_nxt = pend - 1'b1;
      end
   end

`ifdef FLAG_BYPASS_EN
   assign flags_ready = (pend_nxt == '0);
   assign flag_z = fw_commit ? zf : dzf;
   assign flag_s = fw_commit ? sf : dsf;
   assign flag_c = fw_commit ? cf : dcf;
`else
   // An issue in the accept cycle is older than the branch, so it must also block.
   assign flags_ready = (pend == '0) && ((state != ST_IDLE) || (pend_nxt == '0));
   assign flag_z = dzf;
   assign flag_s = dsf;
   assign flag_c = dcf;
   logic unused_raw_flags;
   assign unused_raw_flags = ^{zf, sf, cf};
`endif

   assign eval_cond   = (state == ST_IDLE) ? br_cond   : lat_cond;
   assign eval_target = (state == ST_IDLE) ? br_target : lat_target;
   assign eval_pc4    = (state == ST_IDLE) ? br_pc4    : lat_pc4;
   assign resolve_go  = cond_uses_flags(eval_cond) ? flags_ready : 1'b1;

   flag_cond_eval u_cond_eval (
      .cond  (eval_cond),
      .z     (flag_z),
      .s     (flag_s),
      .c     (flag_c),
      .taken (taken_eval)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (br_valid) state_nxt = resolve_go ? ST_RESOLVE : ST_WAIT;
         ST_WAIT:    if (resolve_go) state_nxt = ST_RESOLVE;
         ST_RESOLVE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      br_ready  = (state == ST_IDLE);
      res_valid = (state == ST_RESOLVE);
      load_req  = (state == ST_IDLE) && br_valid;
      load_res  = (state != ST_RESOLVE) && (state_nxt == ST_RESOLVE);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         pend     <= '0;
         pend_ovf <= 1'b0;
      end else begin
         pend <= pend_nxt;
         if (ovf_set) pend_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         lat_cond   <= COND_NEVER;
         lat_target <= '0;
         lat_pc4    <= '0;
      end else if (load_req) begin
         lat_cond   <= br_cond;
         lat_target <= br_target;
         lat_pc4    <= br_pc4;
      end
   end

   // Result registers hold between resolves so fetch may sample them late.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         res_taken <= 1'b0;
         pc_next   <= '0;
      end else if (load_res) begin
         res_taken <= taken_eval;
         pc_next   <= taken_eval ? eval_target : eval_pc4;
      end
   end

endmodule
